// File: rtl/bsg_fsb_pkg.sv
// Shared front side bus defaults, common to the hop-in and hop-out stages.
package bsg_fsb_pkg;

  localparam int fsb_width_gp  = 16;
  localparam int fsb_fan_in_gp = 2;

  // Round-robin successor of index idx among n producers.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_front_side_bus_rr_pick.sv
// Round-robin selector: first valid producer at or after prio_i, wrapping.
module bsg_front_side_bus_rr_pick
  import bsg_fsb_pkg::*;
#(
  parameter int fan_in_p = fsb_fan_in_gp,
  localparam int IDX_W   = $clog2(fan_in_p)
) (
  input  logic [fan_in_p-1:0] v_i,
  input  logic [IDX_W-1:0]    prio_i,
  output logic [fan_in_p-1:0] grant_oh_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                any_v_o
);

  int               sum;
  logic [IDX_W-1:0] idx;

  assign any_v_o = |v_i;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant_idx_o = '0;
    sum         = 0;
    idx         = '0;
    for (int off = fan_in_p - 1; off >= 0; off--) begin
      sum = int'(prio_i) + off;
      if (sum >= fan_in_p) sum = sum - fan_in_p;
      idx = IDX_W'(sum);
      if (v_i[idx]) grant_idx_o = idx;
    end
    grant_oh_o = '0;
    if (any_v_o) grant_oh_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO; ready_o comes from the registered full flag only.
module bsg_two_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem_q, mem_d;
  logic                    head_q, head_d;
  logic                    tail_q, tail_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (v_i) begin
      mem_d[tail_q] = data_i;
      tail_d        = ~tail_q;
    end
    if (yumi_i) head_d = ~head_q;
    // Occupancy only changes when exactly one side moves.
    if (v_i & ~yumi_i) begin
      empty_d = 1'b0;
      full_d  = (tail_d == head_q);
    end else if (yumi_i & ~v_i) begin
      full_d  = 1'b0;
      empty_d = (head_d == tail_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// Front side bus merge point: round-robin over fan_in_p producers into a
// two-entry buffer driving one valid/ready link.
module bsg_front_side_bus_hop_out
  import bsg_fsb_pkg::*;
#(
  parameter int width_p  = fsb_width_gp,
  parameter int fan_in_p = fsb_fan_in_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [fan_in_p-1:0]         v_i,
  input  logic [fan_in_p*width_p-1:0] data_i,
  output logic [fan_in_p-1:0]         yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_i
);

  localparam int IDX_W = $clog2(fan_in_p);

  logic [IDX_W-1:0]    prio_q, prio_d;
  logic [fan_in_p-1:0] grant_oh;
  logic [IDX_W-1:0]    grant_idx;
  logic                any_v;
  logic                buf_ready;
  logic                enq, deq;
  logic [width_p-1:0]  grant_data;

  bsg_front_side_bus_rr_pick #(.fan_in_p(fan_in_p)) pick (
    .v_i         (v_i),
    .prio_i      (prio_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_v_o     (any_v)
  );

  assign enq        = any_v & buf_ready & ~reset_i;
  assign deq        = v_o & ready_i;
  assign yumi_o     = enq ? grant_oh : '0;
  assign grant_data = data_i[grant_idx*width_p +: width_p];

  always_comb begin
    prio_d = prio_q;
    if (enq) prio_d = IDX_W'(rr_next(int'(grant_idx), fan_in_p));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) prio_q <= '0;
    else         prio_q <= prio_d;
  end

  bsg_two_fifo #(.width_p(width_p)) obuf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (buf_ready),
    .data_i  (grant_data),
    .v_i     (enq),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (deq)
  );

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
// Bench for bsg_front_side_bus_hop_out: directed table, corner sequences,
// and constrained-random traffic against a queue-based reference model.
module tb_bsg_front_side_bus_hop_out;

  localparam int W = 16;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_i;

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_out #(.width_p(W), .fan_in_p(N)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .yumi_o  (yumi_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffer contents as a queue plus a priority index.
  logic [W-1:0] m_q[$];
  int           m_prio;
  logic [N-1:0] m_yumi;
  logic         m_vo;
  logic         m_enq;
  int           m_g;

  logic [N-1:0] s_yumi;
  logic         s_vo;
  logic [W-1:0] s_data;

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic [W-1:0] d0, d1, d2;
    logic         ready;
    logic [N-1:0] yumi;
    logic         vo;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] v, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic [W-1:0] d2, input logic rdy);
    reset_i = rst;
    v_i     = v;
    data_i  = {d2, d1, d0};
    ready_i = rdy;
  endtask

  task automatic model_eval();
    m_vo   = (m_q.size() > 0);
    m_enq  = (|v_i) && (m_q.size() < 2) && !reset_i;
    m_g    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      int i;
      i = (m_prio + k) % N;
      if (v_i[i]) m_g = i;
    end
    m_yumi = m_enq ? N'(1 << m_g) : '0;
  endtask

  task automatic model_update();
    if (reset_i) begin
      m_q.delete();
      m_prio = 0;
    end else begin
      if (m_vo && ready_i) void'(m_q.pop_front());
      if (m_enq) begin
        m_q.push_back(data_i[m_g*W +: W]);
        m_prio = (m_g + 1) % N;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    s_yumi = yumi_o;
    s_vo   = v_o;
    s_data = data_o;
    chk("yumi_o", W'(s_yumi), W'(m_yumi));
    chk("v_o", W'(s_vo), W'(m_vo));
    if (m_vo) chk("data_o", s_data, m_q[0]);
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [W-1:0] pdata[N];
  logic [N-1:0] pend;
  int           ycount;
  logic [N-1:0] g1, g2;
  logic [W-1:0] seq_d0;

  initial begin
    m_prio = 0;
    tbl[0]  = '{1, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b000, 0, 16'h0};
    tbl[1]  = '{1, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b000, 0, 16'h0};
    tbl[2]  = '{1, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b000, 0, 16'h0};
    tbl[3]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b001, 0, 16'h0};
    tbl[4]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b010, 1, 16'h0000};
    tbl[5]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b100, 1, 16'h1111};
    tbl[6]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b001, 1, 16'h2222};
    tbl[7]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b010, 1, 16'h0000};
    tbl[8]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b100, 1, 16'h1111};
    tbl[9]  = '{0, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1, 3'b001, 1, 16'h2222};
    tbl[10] = '{0, 3'b010, 16'h0000, 16'hA5A5, 16'h2222, 1, 3'b010, 1, 16'h0000};
    tbl[11] = '{0, 3'b010, 16'h0000, 16'hA5A5, 16'h2222, 1, 3'b010, 1, 16'hA5A5};
    tbl[12] = '{0, 3'b010, 16'h0000, 16'hA5A5, 16'h2222, 1, 3'b010, 1, 16'hA5A5};

    // Initial reset edge so the state is defined before the first check.
    drive(1, 3'b111, 16'h0000, 16'h1111, 16'h2222, 1);
    @(posedge clk);
    #1;
    m_q.delete();
    m_prio = 0;

    // Reset hold, fairness rotation, single producer streaming.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].ready);
      cycle();
      chk("tbl_yumi", W'(s_yumi), W'(tbl[i].yumi));
      chk("tbl_v_o", W'(s_vo), W'(tbl[i].vo));
      if (tbl[i].vo) chk("tbl_data_o", s_data, tbl[i].dout);
    end

    // Backpressure: from empty, exactly two words accepted.
    drive(0, 3'b000, 0, 0, 0, 1);
    repeat (3) cycle();
    ycount = 0;
    seq_d0 = 16'hB000;
    for (int c = 0; c < 5; c++) begin
      drive(0, 3'b001, seq_d0, 0, 0, 0);
      cycle();
      if (s_yumi[0]) begin
        ycount++;
        seq_d0 = seq_d0 + 1;
      end
    end
    chk("bp_yumi_count", W'(ycount), 16'd2);
    chk("bp_v_o_held", W'(s_vo), 16'd1);
    chk("bp_head_word", s_data, 16'hB000);
    drive(0, 3'b000, 0, 0, 0, 1);
    cycle();
    chk("bp_drain0", s_data, 16'hB000);
    cycle();
    chk("bp_drain1", s_data, 16'hB001);
    cycle();

    // Pointer holds while full; release grants 2 then 0.
    drive(0, 3'b010, 0, 16'hC001, 0, 0);
    cycle();
    drive(0, 3'b010, 0, 16'hC002, 0, 0);
    cycle();
    for (int c = 0; c < 4; c++) begin
      drive(0, 3'b101, 16'hD000, 0, 16'hD222, 0);
      cycle();
      chk("hold_no_grant", W'(s_yumi), 16'd0);
    end
    g1 = '0;
    g2 = '0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 3'b101, 16'hD000, 0, 16'hD222, 1);
      cycle();
      if (s_yumi != '0) begin
        if (g1 == '0) g1 = s_yumi;
        else if (g2 == '0) g2 = s_yumi;
      end
    end
    chk("hold_first_grant", W'(g1), 16'h0004);
    chk("hold_second_grant", W'(g2), 16'h0001);

    // Reset with two words buffered discards them.
    drive(0, 3'b000, 0, 0, 0, 1);
    repeat (3) cycle();
    drive(0, 3'b001, 16'hE001, 0, 0, 0);
    cycle();
    drive(0, 3'b001, 16'hE002, 0, 0, 0);
    cycle();
    drive(1, 3'b000, 0, 0, 0, 0);
    cycle();
    chk("mid_pre_v_o", W'(s_vo), 16'd1);
    for (int c = 0; c < 3; c++) begin
      drive(0, 3'b000, 0, 0, 0, 1);
      cycle();
      chk("mid_post_v_o", W'(s_vo), 16'd0);
    end

    // Random traffic obeying the producer protocol.
    pend = '0;
    for (int k = 0; k < N; k++) pdata[k] = '0;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(2) == 0)) begin
          pend[k]  = 1'b1;
          pdata[k] = W'($urandom);
        end
      end
      drive(($urandom_range(99) == 0), pend, pdata[0], pdata[1], pdata[2],
            ($urandom_range(3) != 0));
      cycle();
      pend = pend & ~m_yumi;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_front_side_bus_hop_out.md
# bsg_front_side_bus_hop_out

Merge point of the front side bus, the counterpart of the fan-out hop-in stage. It takes `fan_in_p` independent valid/yumi producers, typically the local node plus the upstream hop, and picks one word per cycle with a round-robin arbiter. The chosen word is enqueued into a two-entry output buffer that drives a single valid/ready link toward the next hop. The arbiter is fair, no producer is starved, and the link sustains one word per cycle.

## Interface
- `width_p`, 16: data word width in bits.
- `fan_in_p`, 2: number of producers merged; must be at least 2.

- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `v_i`  in  fan_in_p: per-producer valid.
- `data_i`  in  fan_in_p*width_p: producer k's word sits at bits [k*width_p +: width_p].
- `yumi_o`  out  fan_in_p: one-hot or zero. Bit k high means producer k's word is consumed this cycle.
- `v_o`  out  1: output word valid.
- `data_o`  out  width_p: output word.
- `ready_i`  in  1: downstream accepts; a transfer occurs when `v_o & ready_i`.

## Operation
- **Output buffer.** Two-entry FIFO, `bsg_two_fifo` semantics.
  - `enq = |v_i & buf_ready & ~reset_i`.
  - `deq = v_o & ready_i`.
  - `v_o = ~empty`.
- **Arbiter state.** `prio_r` is the index of the highest-priority producer, width `$clog2(fan_in_p)`.
- **Grant rule.** Scan `prio_r`, `prio_r+1`, … modulo `fan_in_p`. The first index with `v_i` set is `g`.
  - `yumi_o[g] = enq`; all other bits are 0.
  - `yumi_o` is combinational from `v_i`. Producers must not make `v_i` depend on `yumi_o`.
- **Pointer update.** On `enq`, `prio_r <= (g == fan_in_p-1) ? 0 : g+1`. Otherwise `prio_r` holds.
- **Buffer full.** `yumi_o` is all zero and `prio_r` holds. A producer's `v_i` stays asserted until it sees its yumi; `data_i` is stable while its `v_i` is high.
- **Buffer empty with no `v_i`.** No grant; `v_o = 0`.
- **Simultaneous enq and deq.**
  - Full buffer: enq is blocked, because `buf_ready` reflects the registered full state. The deq alone proceeds, and the next cycle accepts a new word.
  - One entry held: enq and deq both happen and occupancy stays at 1.
- **Order.** Word order is preserved per producer and across producers in grant order. No word is duplicated or dropped.
- **Reset.**
  - While `reset_i` is high: `yumi_o = 0` and `v_o = 0` in the cycle after reset is sampled; `prio_r <= 0`; buffer set to empty with head and tail at 0.
  - Reset mid-transfer discards any buffered words.
  - Producers holding `v_i` through reset are granted starting from index 0 once `reset_i` falls.

## Timing
- Reset values: `v_o = 0`, `yumi_o = 0`, `prio_r = 0`, buffer empty. `data_o` is don't-care while `v_o = 0`.
- Latency: a word granted (`yumi_o` high) in cycle t appears on `v_o`/`data_o` in cycle t+1 if the buffer was empty. Otherwise it appears after the older entry drains.
- Throughput: one word per cycle when `ready_i` is held high.
- Backpressure: with `ready_i = 0`, two words are accepted, then `yumi_o` stays 0.
- With `ready_i` stuck at 1 and all `v_i` high, grants rotate 0, 1, …, fan_in_p-1, 0, one per cycle.

## Structure
- Top module `bsg_front_side_bus_hop_out` holds `prio_r` and the grant logic, and instantiates `bsg_two_fifo` with `width_p` for the output buffer.
- The round-robin selector is natural as one sub-module, `bsg_front_side_bus_rr_pick`:
  - inputs: `v_i`, `prio`.
  - outputs: grant one-hot, grant index, any-valid.
- Shared package `bsg_fsb_pkg` holds the bus word width default and the fan-in default, so they match the hop-in stage.

## Test plan
All scenarios use `fan_in_p = 3`, `width_p = 16`.
- **Reset:** hold `reset_i` 3 cycles with `v_i = 3'b111` -> `yumi_o = 0` and `v_o = 0` throughout. The first cycle after reset grants producer 0 (`yumi_o = 3'b001`).
- **Single producer, no backpressure:** `v_i = 3'b010` with `data_i[31:16] = 16'hA5A5`, `ready_i = 1` -> `yumi_o = 3'b010` every cycle; `v_o = 1`, `data_o = 16'hA5A5` one cycle later.
- **Fairness:** all three valid with data 16'h0000, 16'h1111, 16'h2222, `ready_i = 1`, for 6 cycles -> `data_o` sequence 0000, 1111, 2222, 0000, 1111, 2222.
- **Backpressure:** `ready_i = 0`, `v_i = 3'b001` -> exactly 2 yumis, then `yumi_o = 0` and `v_o = 1` holding the first word. Raising `ready_i` drains both in order and resumes grants.
- **Pointer hold while full:** buffer full, `prio_r = 2`, `v_i = 3'b101` for 4 cycles -> no grant. When `ready_i` rises, the first grant goes to producer 2, then 0.
- **Reset mid-stream:** assert `reset_i` with 2 words buffered -> `v_o = 0` the next cycle and the buffered words are never emitted.
